// File: rtl/booth16_pkg.sv
// Shared types and constants for the radix-16 Booth partial-product generator.
package booth16_pkg;

    localparam int unsigned N_DEF = 16;

    typedef enum logic [1:0] {
        StIdle,
        StPrecomp,
        StEmit
    } state_e;

    // Radix-16 Booth digit, range -8..+8
    typedef logic signed [4:0] digit_t;

endpackage

// File: rtl/booth16_mult_sel.sv
// Combinational radix-16 Booth digit decode and multiple select: pp_o = d * M.
module booth16_mult_sel
    import booth16_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic [4:0]          window_i,
    input  logic signed [N+3:0] m_i,
    input  logic signed [N+3:0] m3_i,
    input  logic signed [N+3:0] m5_i,
    input  logic signed [N+3:0] m7_i,
    output logic signed [N+3:0] pp_o
);

    digit_t              digit;
    digit_t              mag_full;
    logic [3:0]          mag;
    logic                neg;
    logic signed [N+3:0] sel;

    always_comb begin
        // window_i = {b[4k+3:4k], b[4k-1]}: signed nibble plus the borrowed bit
        digit    = digit_t'({window_i[4], window_i[4:1]}) + digit_t'({4'b0000, window_i[0]});
        neg      = digit[4];
        mag_full = neg ? -digit : digit;
        mag      = mag_full[3:0];

        sel = '0;
        case (mag)
            4'd1:    sel = m_i;
            4'd2:    sel = m_i <<< 1;
            4'd3:    sel = m3_i;
            4'd4:    sel = m_i <<< 2;
            4'd5:    sel = m5_i;
            4'd6:    sel = m3_i <<< 1;
            4'd7:    sel = m7_i;
            4'd8:    sel = m_i <<< 3;
            default: sel = '0;
        endcase

        pp_o = neg ? -sel : sel;
    end

endmodule

// File: rtl/booth16_pp_gen.sv
// Sequential radix-16 Booth partial-product generator: one signed d_k*a per output beat,
// least-significant digit first, after a single precompute cycle for the odd multiples.
module booth16_pp_gen
    import booth16_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    output logic                       ready_o,
    input  logic [N-1:0]               a_i,
    input  logic [N-1:0]               b_i,
    output logic [N+3:0]               pp_o,
    output logic                       pp_valid_o,
    input  logic                       pp_ready_i,
    output logic [$clog2(N/4)-1:0]     pp_idx_o,
    output logic                       pp_last_o
);

    localparam int unsigned IdxW = $clog2(N/4);
    localparam logic [IdxW-1:0] PenultIdx = IdxW'(N/4 - 2);

    state_e              state_q;
    logic signed [N+3:0] m_q, m3_q, m5_q, m7_q;
    logic [N-1:0]        b_q;
    logic                b_prev_q;
    logic [IdxW-1:0]     cnt_q;
    logic [N+3:0]        pp_q;
    logic                valid_q;
    logic                last_q;

    logic signed [N+3:0] m3_c, m5_c, m7_c;
    logic signed [N+3:0] m3_use, m5_use, m7_use;
    logic [4:0]          window;
    logic signed [N+3:0] sel_pp;

    assign m3_c = m_q + (m_q <<< 1);
    assign m5_c = m_q + (m_q <<< 2);
    assign m7_c = (m_q <<< 3) - m_q;

    // Beat 0 is formed while the multiples are still being registered, so bypass them.
    // In EMIT the window looks one digit ahead so pp_q is ready on the handshake.
    always_comb begin
        if (state_q == StPrecomp) begin
            m3_use = m3_c;
            m5_use = m5_c;
            m7_use = m7_c;
            window = {b_q[3:0], b_prev_q};
        end else begin
            m3_use = m3_q;
            m5_use = m5_q;
            m7_use = m7_q;
            window = {b_q[7:4], b_q[3]};
        end
    end

    booth16_mult_sel #(
        .N(N)
    ) u_mult_sel (
        .window_i (window),
        .m_i      (m_q),
        .m3_i     (m3_use),
        .m5_i     (m5_use),
        .m7_i     (m7_use),
        .pp_o     (sel_pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            m_q      <= '0;
            m3_q     <= '0;
            m5_q     <= '0;
            m7_q     <= '0;
            b_q      <= '0;
            b_prev_q <= 1'b0;
            cnt_q    <= '0;
            pp_q     <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        m_q      <= {{4{a_i[N-1]}}, a_i};
                        b_q      <= b_i;
                        b_prev_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= StPrecomp;
                    end
                end
                StPrecomp: begin
                    m3_q    <= m3_c;
                    m5_q    <= m5_c;
                    m7_q    <= m7_c;
                    pp_q    <= sel_pp;
                    valid_q <= 1'b1;
                    last_q  <= 1'b0;
                    state_q <= StEmit;
                end
                StEmit: begin
                    if (pp_ready_i) begin
                        b_prev_q <= b_q[3];
                        b_q      <= b_q >> 4;
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            pp_q    <= '0;
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q  <= cnt_q + 1'b1;
                            last_q <= (cnt_q == PenultIdx);
                            pp_q   <= sel_pp;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o    = (state_q == StIdle);
    assign pp_o       = pp_q;
    assign pp_valid_o = valid_q;
    assign pp_idx_o   = cnt_q;
    assign pp_last_o  = last_q;

endmodule

// File: tb/tb_booth16_pp_gen.sv
// Scoreboard bench for booth16_pp_gen: directed operand pairs with hand-computed beats.
module tb_booth16_pp_gen;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        ready_o;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic [19:0] pp_o;
    logic        pp_valid_o;
    logic        pp_ready_i;
    logic [1:0]  pp_idx_o;
    logic        pp_last_o;

    booth16_pp_gen #(
        .N(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .ready_o    (ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .pp_o       (pp_o),
        .pp_valid_o (pp_valid_o),
        .pp_ready_i (pp_ready_i),
        .pp_idx_o   (pp_idx_o),
        .pp_last_o  (pp_last_o)
    );

    typedef struct packed {
        logic [19:0] pp;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    exp_t   exp_q[$];
    longint prod_q[$];
    int     total = 0;
    int     bad   = 0;
    exp_t   e;
    longint acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected beat per output handshake
    always @(negedge clk) begin
        if (rst_n && pp_valid_o && pp_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got idx=%0d pp=%05h required no beat", pp_idx_o, pp_o);
            end else begin
                e = exp_q.pop_front();
                chk("beat_pp", pp_o, e.pp);
                chk("beat_idx", pp_idx_o, e.idx);
                chk("beat_last", pp_last_o, e.last);
            end
            if (pp_idx_o == 2'd0) acc = longint'($signed(pp_o));
            else acc = acc + (longint'($signed(pp_o)) <<< (4 * pp_idx_o));
            if (pp_last_o) begin
                if (prod_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL product: got %0d required no completed operation", acc);
                end else begin
                    chk("product", acc, prod_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [19:0] e0, input logic [19:0] e1,
                         input logic [19:0] e2, input logic [19:0] e3, input int nexp);
        logic [19:0] ev[4];
        longint sa, sb;
        int n;
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", ready_o, 1);
        for (int k = 0; k < nexp; k++)
            exp_q.push_back('{pp: ev[k], idx: 2'(k), last: (k == 3)});
        if (nexp == 4) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            prod_q.push_back(sa * sb);
        end
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start_i = 1'b0;
        pp_ready_i = 1'b1;
        a_i = '0;
        b_i = '0;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", pp_valid_o, 0);
        chk("rst_last", pp_last_o, 0);
        chk("rst_pp", pp_o, 0);
        chk("rst_idx", pp_idx_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // a=3, b=5: latency and ready timing
        issue(16'h0003, 16'h0005, 20'h0000F, 20'h0, 20'h0, 20'h0, 4);
        chk("precomp_valid", pp_valid_o, 0);
        chk("precomp_ready", ready_o, 0);
        @(posedge clk); #1;
        chk("first_valid", pp_valid_o, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("last_beat_ready", ready_o, 0);
        chk("last_beat_flag", pp_last_o, 1);
        @(posedge clk); #1;
        chk("ready_rises", ready_o, 1);
        chk("valid_drops", pp_valid_o, 0);

        issue(16'hFFF9, 16'h0008, 20'h00038, 20'hFFFF9, 20'h0, 20'h0, 4);
        wait_idle();
        issue(16'h7FFF, 16'h8000, 20'h0, 20'h0, 20'h0, 20'hC0008, 4);
        wait_idle();
        issue(16'h8000, 16'h8000, 20'h0, 20'h0, 20'h0, 20'h40000, 4);
        wait_idle();
        issue(16'h1234, 16'hFFFF, 20'hFEDCC, 20'h0, 20'h0, 20'h0, 4);
        wait_idle();
        issue(16'h0010, 16'h0777, 20'h00070, 20'h00070, 20'h00070, 20'h0, 4);
        wait_idle();
        issue(16'hFFFD, 16'h3650, 20'h0, 20'hFFFF1, 20'hFFFEE, 20'hFFFF7, 4);
        wait_idle();

        // Backpressure on idx 1, with a stray start pulse that must be ignored
        issue(16'h0003, 16'h00C4, 20'h0000C, 20'hFFFF4, 20'h00003, 20'h0, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pp_ready_i = 1'b0;
        a_i = 16'h1111;
        b_i = 16'h1111;
        start_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", pp_valid_o, 1);
            chk("stall_idx", pp_idx_o, 1);
            chk("stall_pp", pp_o, 20'hFFFF4);
            chk("stall_last", pp_last_o, 0);
        end
        start_i = 1'b0;
        pp_ready_i = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("no_stray_op", pp_valid_o, 0);

        // Asynchronous reset during idx 2; only beats 0 and 1 complete
        issue(16'h0003, 16'h1111, 20'h00003, 20'h00003, 20'h0, 20'h0, 2);
        repeat (3) @(posedge clk);
        #1;
        pp_ready_i = 1'b0;
        chk("pre_rst_idx", pp_idx_o, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", ready_o, 1);
        chk("arst_valid", pp_valid_o, 0);
        chk("arst_last", pp_last_o, 0);
        chk("arst_pp", pp_o, 0);
        chk("arst_idx", pp_idx_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pp_ready_i = 1'b1;
        issue(16'h0002, 16'h0001, 20'h00002, 20'h0, 20'h0, 20'h0, 4);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 0);
        chk("prod_empty", prod_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth16_pp_gen.md
# booth16_pp_gen

Sequential radix-16 Booth partial-product generator for the multiplier datapath. Accepts a signed multiplicand/multiplier pair through a valid/ready handshake, precomputes the odd multiples of the multiplicand, then emits one signed partial product per accepted output beat, least-significant digit first. Sits directly upstream of the partial-product shift/accumulate stage, which consumes one `pp_o` per cycle.

## Interface
- `N`, 16, operand width in bits, signed two's complement; must be a multiple of 4 and ≥ 8
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  operand valid; accepted when `start_i && ready_o`
- `ready_o`  out  1  high only in IDLE
- `a_i`  in  N  multiplicand, signed
- `b_i`  in  N  multiplier, signed
- `pp_o`  out  N+4  signed partial product `d_k * a`, unshifted
- `pp_valid_o`  out  1  `pp_o` valid
- `pp_ready_i`  in  1  downstream accepts `pp_o` when `pp_valid_o && pp_ready_i`
- `pp_idx_o`  out  $clog2(N/4)  digit index k of current `pp_o`, 0 first
- `pp_last_o`  out  1  high with the beat for k = N/4−1

## Operation
- FSM states: IDLE, PRECOMP, EMIT.
- IDLE: `ready_o`=1. On accept, register `a_i` as M (N+4 sign-extended), `b_i` into multiplier shift register, clear `b_prev` (the b[−1] bit), clear digit counter; go PRECOMP. `start_i` outside IDLE is ignored.
- PRECOMP (exactly 1 cycle): register 3M = M+2M, 5M = M+4M, 7M = 8M−M, all N+4 bits; go EMIT.
- EMIT: digit d_k = −8·b[4k+3] + 4·b[4k+2] + 2·b[4k+1] + b[4k] + b[4k−1], b[−1]=0, range −8..+8. Magnitude selects from {0, M, 2M, 3M, 4M, 5M, 6M=3M<<1, 7M, 8M}; negative digits negate exactly (two's complement, no deferred +1 hot bit). Result is truncated to N+4 bits and never overflows.
- On each output handshake: `b_prev` ← current b[3], multiplier shifts right by 4, counter increments. Handshake on the last beat returns to IDLE.
- `pp_o` is registered. `pp_o`, `pp_idx_o`, and `pp_last_o` are held stable while `pp_valid_o && !pp_ready_i`.
- Zero digits are emitted as beats with value 0. The block never skips a beat.

## Timing
- Reset values: `ready_o`=1, `pp_valid_o`=0, `pp_last_o`=0, `pp_o`=0, `pp_idx_o`=0. All internal registers are 0. State is IDLE.
- Accept at cycle t → PRECOMP at t+1 → first `pp_valid_o` at t+2.
- With `pp_ready_i` tied high, beats occur at t+2 … t+1+N/4 and `ready_o` rises at t+2+N/4. Total is N/4+2 cycles per operation.
- No back-to-back overlap: the next accept is possible at the earliest in the cycle after the last handshake.
- Reset asserted mid-operation: outputs take their reset values immediately (async) and the operation is discarded. The block restarts clean in IDLE after deassert.
- `pp_valid_o` is only deasserted on the last handshake. It never drops without a handshake.

## Structure
- Shared package `booth16_pkg`: state enum (IDLE/PRECOMP/EMIT), signed digit typedef (5-bit), default N constant.
- One combinational sub-module `booth16_mult_sel`. Inputs: 5-bit Booth window and M/3M/5M/7M. Output: signed `d·M` (N+4 bits). It contains the decode, the shift-multiples, the mux, and the negate.
- Top level holds the FSM, the operand/multiple registers, the multiplier shifter, the counter, and the output register.

## Test plan
- N=16, a=3, b=5, `pp_ready_i`=1 → four beats 0x0000F, 0, 0, 0; `pp_last_o` only on idx 3; first valid 2 cycles after accept.
- a=−7 (0xFFF9), b=0x0008 → pp0=0x00038 (−8·−7), pp1=0xFFFF9 (+1 from b[3] carry-in), pp2=pp3=0.
- Extremes: a=0x7FFF, b=0x8000 → pp3=0xC0008. a=0x8000, b=0x8000 → pp3=0x40000. Other beats are 0. Check Σ pp_k·16^k equals a·b for 10k random pairs.
- Backpressure: hold `pp_ready_i`=0 for 3 cycles on idx 1 → `pp_o`/idx stable. `start_i` pulsed during EMIT is ignored.
- Pulse `rst_n` low during EMIT idx 2 → outputs return to reset values asynchronously. A new operation a=2, b=1 then yields 0x00002, 0, 0, 0.
